multicycle_mips_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS top.
- Shares one unified word-addressed memory between instructions and data.
- Sequences each instruction through an FSM, one phase per clock: FETCH / DECODE / EXEC / MEM / WB.
- Adds over the single-cycle top: configurable memory depth and reset vector, a retire strobe, halt on illegal instruction, and load-port stall.

---
 rtl/multicycle_mips_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_mips_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS subset core with one shared word-addressed memory.
// Each instruction walks FETCH/DECODE/EXEC/MEM/WB, one phase per clock.
// An external load port can write memory at any time and holds the core in FETCH.
module multicycle_mips_core #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [31:0] i_w_addr,
  input  logic [31:0] i_w_ins,
  output logic [31:0] o_pc,
  output logic [31:0] o_result,
  output logic        o_retire,
  output logic        o_halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_mdr;
  logic [31:0] r_alu_out;

  logic [31:0] r_mem [0:(2**ADDR_W)-1];
  logic [31:0] r_rf  [0:31];

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_sext;
  logic [31:0] w_br_off;
  logic [31:0] w_jump_target;

  assign w_op          = r_ir[31:26];
  assign w_rs          = r_ir[25:21];
  assign w_rt          = r_ir[20:16];
  assign w_rd          = r_ir[15:11];
  assign w_funct       = r_ir[5:0];
  assign w_imm_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_br_off      = {w_imm_sext[29:0], 2'b00};
  assign w_jump_target = {r_pc[31:28], r_ir[25:0], 2'b00};

  // Upper/lower load-address bits are intentionally ignored so addresses wrap.
  logic w_unused_addr;
  assign w_unused_addr = ^{i_w_addr[31:ADDR_W+2], i_w_addr[1:0]};

  // Combinational memory and register-file reads; $0 always reads zero
  logic [31:0] w_fetch_word;
  logic [31:0] w_load_word;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;

  assign w_fetch_word = r_mem[r_pc[ADDR_W+1:2]];
  assign w_load_word  = r_mem[r_alu_out[ADDR_W+1:2]];
  assign w_rs_val     = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val     = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

  // Opcode classification and legality check
  logic w_is_r;
  logic w_is_addi;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_beq;
  logic w_is_j;
  logic w_funct_ok;
  logic w_legal;

  assign w_is_r     = (w_op == OP_RTYPE);
  assign w_is_addi  = (w_op == OP_ADDI);
  assign w_is_lw    = (w_op == OP_LW);
  assign w_is_sw    = (w_op == OP_SW);
  assign w_is_beq   = (w_op == OP_BEQ);
  assign w_is_j     = (w_op == OP_J);
  assign w_funct_ok = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                      (w_funct == FN_OR)  || (w_funct == FN_SLT);
  assign w_legal    = (w_is_r && w_funct_ok) || w_is_addi || w_is_lw || w_is_sw ||
                      w_is_beq || w_is_j;

  // R-type ALU; slt compares as signed
  logic [31:0] w_alu_r;
  always_comb begin
    w_alu_r = 32'd0;
    case (w_funct)
      FN_ADD:  w_alu_r = r_a + r_b;
      FN_SUB:  w_alu_r = r_a - r_b;
      FN_AND:  w_alu_r = r_a & r_b;
      FN_OR:   w_alu_r = r_a | r_b;
      FN_SLT:  w_alu_r = {31'd0, ($signed(r_a) < $signed(r_b))};
      default: w_alu_r = 32'd0;
    endcase
  end

  // Next-state logic plus per-phase strobes (retire, register write, store)
  logic        w_retire;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic        w_sw_en;
  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    w_rf_we      = 1'b0;
    w_rf_waddr   = 5'd0;
    w_rf_wdata   = 32'd0;
    w_sw_en      = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!i_we) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_state_next = S_HALT;
        end else if (w_is_j) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_beq) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        if (w_is_sw) begin
          w_sw_en      = 1'b1;
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_WB: begin
        w_retire     = 1'b1;
        w_rf_we      = 1'b1;
        w_state_next = S_FETCH;
        if (w_is_r) begin
          w_rf_waddr = w_rd;
          w_rf_wdata = r_alu_out;
        end else if (w_is_lw) begin
          w_rf_waddr = w_rt;
          w_rf_wdata = r_mdr;
        end else begin
          w_rf_waddr = w_rt;
          w_rf_wdata = r_alu_out;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_state_next;
  end

  // Datapath registers updated by the phase currently executing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_mdr     <= 32'd0;
      r_alu_out <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!i_we) begin
            r_ir <= w_fetch_word;
            r_pc <= r_pc + 32'd4;
          end
        end
        S_DECODE: begin
          r_a       <= w_rs_val;
          r_b       <= w_rt_val;
          r_alu_out <= r_pc + w_br_off;
          if (w_is_j) r_pc <= w_jump_target;
        end
        S_EXEC: begin
          if (w_is_beq) begin
            if (r_a == r_b) r_pc <= r_alu_out;
          end else if (w_is_r) begin
            r_alu_out <= w_alu_r;
          end else begin
            r_alu_out <= r_a + w_imm_sext;
          end
        end
        S_MEM: begin
          if (w_is_lw) r_mdr <= w_load_word;
        end
        default: begin
        end
      endcase
    end
  end

  // Register file write port; $0 is never written
  always_ff @(posedge i_clk) begin
    if (w_rf_we && (w_rf_waddr != 5'd0)) r_rf[w_rf_waddr] <= w_rf_wdata;
  end

  // Memory write ports; the load port is applied last so it wins a same-word clash
  always_ff @(posedge i_clk) begin
    if (w_sw_en) r_mem[r_alu_out[ADDR_W+1:2]] <= r_b;
    if (i_we)    r_mem[i_w_addr[ADDR_W+1:2]]  <= i_w_ins;
  end

  assign o_pc     = r_pc;
  assign o_result = r_alu_out;
  assign o_retire = w_retire;
  assign o_halted = (r_state == S_HALT);

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Directed bench for multicycle_mips_core: programs are loaded through the
// load port while reset is held, then run with cycle-exact checks.
module tb_multicycle_mips_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [31:0] w_addr = 32'd0;
  logic [31:0] w_ins = 32'd0;
  logic [31:0] pc;
  logic [31:0] result;
  logic        retire;
  logic        halted;

  logic        rst4_n = 1'b1;
  logic        we4 = 1'b0;
  logic [31:0] w_addr4 = 32'd0;
  logic [31:0] w_ins4 = 32'd0;
  logic [31:0] pc4;
  logic [31:0] result4;
  logic        retire4;
  logic        halted4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nret     = 0;

  multicycle_mips_core dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_w_addr(w_addr), .i_w_ins(w_ins),
    .o_pc(pc), .o_result(result), .o_retire(retire), .o_halted(halted)
  );

  multicycle_mips_core #(.ADDR_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .i_we(we4), .i_w_addr(w_addr4), .i_w_ins(w_ins4),
    .o_pc(pc4), .o_result(result4), .o_retire(retire4), .o_halted(halted4)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; w_addr = a; w_ins = d;
    @(negedge clk);
  endtask

  // Called at a negedge: drop WE, release reset; this negedge is mid-cycle 1.
  task automatic go();
    we = 1'b0; rst_n = 1'b1; cyc = 1; nret = 0;
  endtask

  task automatic advance_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
      if (retire) nret++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0; rst4_n = 1'b0;
    #1;
    check_val("reset_pc", pc, 32'h0);
    check_val("reset_result", result, 32'h0);
    check_val("reset_retire", {31'd0, retire}, 32'd0);
    check_val("reset_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);

    // Arithmetic sequence, preceded by a 5-cycle load-port stall in FETCH
    load_word(32'h0, 32'h2001_0005);   // addi $1,$0,5
    load_word(32'h4, 32'h2002_FFFD);   // addi $2,$0,-3
    load_word(32'h8, 32'h0022_1820);   // add  $3,$1,$2
    rst_n = 1'b1; we = 1'b1; w_addr = 32'h200; w_ins = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_pc", pc, 32'h0);
      check_val("stall_retire", {31'd0, retire}, 32'd0);
    end
    go();
    advance_to(3);  check_val("arith_c3_retire", {31'd0, retire}, 32'd0);
    advance_to(4);  check_val("arith_c4_retire", {31'd0, retire}, 32'd1);
    check_val("arith_addi1", result, 32'h5);
    advance_to(8);  check_val("arith_c8_retire", {31'd0, retire}, 32'd1);
    check_val("arith_addi2", result, 32'hFFFF_FFFD);
    advance_to(12); check_val("arith_c12_retire", {31'd0, retire}, 32'd1);
    check_val("arith_add", result, 32'h2);
    check_val("arith_pc", pc, 32'hC);
    check_val("arith_nret", nret, 32'd3);

    // Memory round trip through sw/lw
    rst_n = 1'b0;
    @(negedge clk);
    load_word(32'h0, 32'h2001_007F);   // addi $1,$0,0x7F
    load_word(32'h4, 32'hAC01_0100);   // sw   $1,0x100($0)
    load_word(32'h8, 32'h8C04_0100);   // lw   $4,0x100($0)
    load_word(32'hC, 32'h0084_2820);   // add  $5,$4,$4
    go();
    advance_to(4);  check_val("mem_addi", result, 32'h7F);
    advance_to(8);  check_val("mem_sw_retire", {31'd0, retire}, 32'd1);
    check_val("mem_sw_addr", result, 32'h100);
    advance_to(12); check_val("mem_lw_c12_retire", {31'd0, retire}, 32'd0);
    advance_to(13); check_val("mem_lw_retire", {31'd0, retire}, 32'd1);
    check_val("mem_lw_addr", result, 32'h100);
    advance_to(17); check_val("mem_add_retire", {31'd0, retire}, 32'd1);
    check_val("mem_add", result, 32'hFE);
    check_val("mem_nret", nret, 32'd4);

    // Branch and jump
    rst_n = 1'b0;
    @(negedge clk);
    load_word(32'h0,   32'h0800_0004); // j 0x10
    load_word(32'h10,  32'h1000_0002); // beq $0,$0,+2
    load_word(32'h1C,  32'h0800_0040); // j 0x100
    load_word(32'h100, 32'hFC00_0000); // illegal
    go();
    advance_to(2);  check_val("j0_retire", {31'd0, retire}, 32'd1);
    advance_to(3);  check_val("j0_pc", pc, 32'h10);
    check_val("j0_result", result, 32'h14);
    advance_to(4);  check_val("beq_c4_retire", {31'd0, retire}, 32'd0);
    advance_to(5);  check_val("beq_retire", {31'd0, retire}, 32'd1);
    check_val("beq_result", result, 32'h1C);
    advance_to(6);  check_val("beq_pc", pc, 32'h1C);
    advance_to(7);  check_val("j1_retire", {31'd0, retire}, 32'd1);
    advance_to(8);  check_val("j1_pc", pc, 32'h100);
    check_val("j1_result", result, 32'h120);
    advance_to(10); check_val("br_halted", {31'd0, halted}, 32'd1);
    check_val("br_halt_pc", pc, 32'h104);
    check_val("br_nret", nret, 32'd3);

    // Illegal instruction halts; WE writes during HALT still land
    rst_n = 1'b0;
    @(negedge clk);
    load_word(32'h0, 32'h2001_0005);   // addi $1,$0,5
    load_word(32'h4, 32'h2002_0006);   // addi $2,$0,6
    load_word(32'h8, 32'hFC00_0000);   // illegal
    go();
    advance_to(10); check_val("ill_c10_halted", {31'd0, halted}, 32'd0);
    advance_to(11); check_val("ill_halted", {31'd0, halted}, 32'd1);
    check_val("ill_pc", pc, 32'hC);
    check_val("ill_result", result, 32'hC);
    we = 1'b1; w_addr = 32'h8; w_ins = 32'h2007_0055;  // addi $7,$0,0x55
    advance_to(12);
    we = 1'b0;
    advance_to(20);
    check_val("ill_hold_halted", {31'd0, halted}, 32'd1);
    check_val("ill_hold_pc", pc, 32'hC);
    check_val("ill_hold_result", result, 32'hC);
    check_val("ill_nret", nret, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    go();
    advance_to(12); check_val("ill_rerun_retire", {31'd0, retire}, 32'd1);
    check_val("ill_rerun_result", result, 32'h55);

    // Reset asserted while lw sits in MEM
    rst_n = 1'b0;
    @(negedge clk);
    load_word(32'h0, 32'h8C04_0100);   // lw $4,0x100($0)
    go();
    advance_to(4);
    check_val("rst_pre_pc", pc, 32'h4);
    check_val("rst_pre_result", result, 32'h100);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_mid_pc", pc, 32'h0);
    check_val("rst_mid_result", result, 32'h0);
    check_val("rst_mid_halted", {31'd0, halted}, 32'd0);
    check_val("rst_mid_retire", {31'd0, retire}, 32'd0);
    @(negedge clk);
    go();
    advance_to(2);  check_val("rst_refetch_pc", pc, 32'h4);
    advance_to(5);  check_val("rst_lw_retire", {31'd0, retire}, 32'd1);
    check_val("rst_lw_result", result, 32'h100);

    // Address wrap on a 16-word instance: 0x40 aliases word 0
    we4 = 1'b1; w_addr4 = 32'h00; w_ins4 = 32'h2001_0001; @(negedge clk);
    w_addr4 = 32'h40; w_ins4 = 32'h2001_0033; @(negedge clk);
    w_addr4 = 32'h04; w_ins4 = 32'hFC00_0000; @(negedge clk);
    we4 = 1'b0; rst4_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("wrap_retire", {31'd0, retire4}, 32'd1);
    check_val("wrap_result", result4, 32'h33);
    repeat (3) @(negedge clk);
    check_val("wrap_halted", {31'd0, halted4}, 32'd1);
    check_val("wrap_pc", pc4, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
